// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the wait-state counter width.
package dmem_pkg;

  localparam int LAT_W = 4;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for loads and stores: write mask, replicated store data,
// alignment check and right-justified, extended load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic        misaligned,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    wmask      = 4'b0000;
    wdata_sh   = wdata;
    misaligned = 1'b0;
    rdata_ext  = '0;
    rbyte      = rword[{addr_lo, 3'b000} +: 8];
    rhalf      = rword[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_WORD: begin
        wmask      = 4'b1111;
        misaligned = (addr_lo != 2'b00);
        rdata_ext  = rword;
      end
      SZ_HALF: begin
        wmask      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh   = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
        rdata_ext  = {{16{is_signed & rhalf[15]}}, rhalf};
      end
      SZ_BYTE: begin
        wmask      = 4'b0001 << addr_lo;
        wdata_sh   = {4{wdata[7:0]}};
        rdata_ext  = {{24{is_signed & rbyte[7]}}, rbyte};
      end
      default: ;  // reserved size is flagged as an error by the caller
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: valid/ready request, LATENCY wait
// states, one-cycle response. Optional debug read port under DMEM_DEBUG_PORT_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wena,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [5:0]  dbg_pos,
  output logic [31:0] dbg_data
`endif
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(LATENCY);

  dmem_state_t       state;
  logic [LAT_W-1:0]  cnt;
  logic              lat_wena;
  logic [1:0]        lat_size;
  logic              lat_signed;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              cur_wena;
  logic [1:0]        cur_size;
  logic              cur_signed;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic [29:0]       word_off;
  logic [IDX_W-1:0]  widx;
  logic              out_of_range;
  logic              err;
  logic [3:0]        wmask;
  logic [31:0]       wdata_sh;
  logic              misaligned;
  logic [31:0]       rdata_ext;

  assign accept = (state == IDLE) && req_valid;

  // With zero wait states the access commits on the accept edge itself, so the
  // checks must see the live request rather than the latched copy.
  assign commit = rst_n && ((accept && (LATENCY == 0)) ||
                            ((state == WAIT) && (cnt == LAT_W'(1))));

  assign cur_wena   = (state == IDLE) ? req_wena   : lat_wena;
  assign cur_size   = (state == IDLE) ? req_size   : lat_size;
  assign cur_signed = (state == IDLE) ? req_signed : lat_signed;
  assign cur_addr   = (state == IDLE) ? req_addr   : lat_addr;
  assign cur_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;

  // Word offset from the base, wrapping; anything below the base wraps high.
  assign word_off     = cur_addr[31:2] - BASE_ADDR[31:2];
  assign widx         = word_off[IDX_W-1:0];
  assign out_of_range = |word_off[29:IDX_W];
  assign err          = out_of_range || misaligned || (cur_size == SZ_RSVD);

  dmem_lane_align u_align (
    .addr_lo    (cur_addr[1:0]),
    .size       (cur_size),
    .is_signed  (cur_signed),
    .wdata      (cur_wdata),
    .rword      (mem[widx]),
    .wmask      (wmask),
    .wdata_sh   (wdata_sh),
    .misaligned (misaligned),
    .rdata_ext  (rdata_ext)
  );

  // NOTE: the memory array is deliberately left out of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (commit && cur_wena && !err) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) mem[widx][8*k +: 8] <= wdata_sh[8*k +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      stall      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      lat_wena   <= 1'b0;
      lat_size   <= SZ_WORD;
      lat_signed <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_wena   <= req_wena;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            stall      <= 1'b1;
            if (LATENCY == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= LAT_INIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - LAT_W'(1);
          if (cnt == LAT_W'(1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          stall     <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          stall     <= 1'b0;
        end
      endcase
      if (commit) begin
        rsp_rdata <= (cur_wena || err) ? 32'h0 : rdata_ext;
        rsp_err   <= err;
      end
    end
  end

`ifdef DMEM_DEBUG_PORT_EN
  assign dbg_data = mem[IDX_W'(dbg_pos)];
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 1, 3, 0),
// table-driven transactions with a response scoreboard plus reset/back-to-back sequences.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int NI = 3;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [NI-1:0]        req_valid;
  logic [NI-1:0]        req_ready;
  logic [NI-1:0]        req_wena;
  logic [NI-1:0][1:0]   req_size;
  logic [NI-1:0]        req_signed;
  logic [NI-1:0][31:0]  req_addr;
  logic [NI-1:0][31:0]  req_wdata;
  logic [NI-1:0]        rsp_valid;
  logic [NI-1:0][31:0]  rsp_rdata;
  logic [NI-1:0]        rsp_err;
  logic [NI-1:0]        stall;
`ifdef DMEM_DEBUG_PORT_EN
  logic [NI-1:0][5:0]   dbg_pos;
  logic [NI-1:0][31:0]  dbg_data;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sbq[$];
  vec_t tbl[$];
  vec_t b2b[$];

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 3 : 0);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    dmem_responder #(
      .DEPTH     (1024),
      .LATENCY   (L),
      .BASE_ADDR (32'h1001_0000)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_wena   (req_wena[g]),
      .req_size   (req_size[g]),
      .req_signed (req_signed[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g]),
      .stall      (stall[g])
`ifdef DMEM_DEBUG_PORT_EN
      ,
      .dbg_pos    (dbg_pos[g]),
      .dbg_data   (dbg_data[g])
`endif
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd; v.er = er; v.ee = ee;
    return v;
  endfunction

  task automatic drive(input int s, input vec_t v);
    req_wena[s]   = v.we;
    req_size[s]   = v.sz;
    req_signed[s] = v.sg;
    req_addr[s]   = v.addr;
    req_wdata[s]  = v.wd;
  endtask

  // One full transaction on instance s; expectation goes through the scoreboard.
  task automatic run_vec(input int s, input vec_t v, input string nm);
    exp_t e;
    int   n;
    int   st;
    sbq.push_back('{rdata: v.er, err: v.ee});
    @(negedge clk);
    drive(s, v);
    req_valid[s] = 1'b1;
    n = 0;
    while (!req_ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({nm, " ready"}, 32'(req_ready[s]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[s] = 1'b0;
    n  = 1;
    st = 0;
    while (!rsp_valid[s] && n < 40) begin
      st += int'(stall[s]);
      @(negedge clk);
      n++;
    end
    st += int'(stall[s]);
    e = sbq.pop_front();
    check({nm, " latency"}, 32'(n), 32'(lat_of(s) + 1));
    check({nm, " stall_cycles"}, 32'(st), 32'(lat_of(s) + 1));
    check({nm, " rdata"}, rsp_rdata[s], e.rdata);
    check({nm, " err"}, 32'(rsp_err[s]), 32'(e.err));
    @(negedge clk);
    check({nm, " pulse"}, 32'(rsp_valid[s]), 32'd0);
  endtask

  task automatic check_reset_outputs(input int s, input string nm);
    check({nm, " req_ready"}, 32'(req_ready[s]), 32'd1);
    check({nm, " stall"},     32'(stall[s]),     32'd0);
    check({nm, " rsp_valid"}, 32'(rsp_valid[s]), 32'd0);
    check({nm, " rsp_rdata"}, rsp_rdata[s],      32'd0);
    check({nm, " rsp_err"},   32'(rsp_err[s]),   32'd0);
  endtask

  initial begin
    int   n;
    int   acc;
    int   prev;
    exp_t e;

    rst_n      = 1'b0;
    req_valid  = '0;
    req_wena   = '0;
    req_size   = '0;
    req_signed = '0;
    req_addr   = '0;
    req_wdata  = '0;
`ifdef DMEM_DEBUG_PORT_EN
    dbg_pos    = {NI{6'd1}};
`endif

    // Main table on the LATENCY=1 instance: {we, size, signed, addr, wdata, exp_rdata, exp_err}.
    tbl.push_back(mk(1, SZ_WORD, 0, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0000_0000, 0));
    tbl.push_back(mk(0, SZ_WORD, 0, 32'h1001_0004, 32'h0,         32'hDEAD_BEEF, 0));
    tbl.push_back(mk(1, SZ_WORD, 0, 32'h1001_0000, 32'h8001_F07F, 32'h0000_0000, 0));
    tbl.push_back(mk(0, SZ_BYTE, 1, 32'h1001_0000, 32'h0,         32'h0000_007F, 0));
    tbl.push_back(mk(0, SZ_BYTE, 1, 32'h1001_0001, 32'h0,         32'hFFFF_FFF0, 0));
    tbl.push_back(mk(0, SZ_BYTE, 0, 32'h1001_0001, 32'h0,         32'h0000_00F0, 0));
    tbl.push_back(mk(0, SZ_HALF, 0, 32'h1001_0002, 32'h0,         32'h0000_8001, 0));
    tbl.push_back(mk(0, SZ_HALF, 1, 32'h1001_0002, 32'h0,         32'hFFFF_8001, 0));
    tbl.push_back(mk(1, SZ_WORD, 0, 32'h1001_0008, 32'h1122_3344, 32'h0000_0000, 0));
    tbl.push_back(mk(1, SZ_BYTE, 0, 32'h1001_000B, 32'h0000_00AA, 32'h0000_0000, 0));
    tbl.push_back(mk(0, SZ_WORD, 0, 32'h1001_0008, 32'h0,         32'hAA22_3344, 0));
    tbl.push_back(mk(1, SZ_HALF, 0, 32'h1001_0006, 32'h0000_BEEF, 32'h0000_0000, 0));
    tbl.push_back(mk(0, SZ_WORD, 0, 32'h1001_0004, 32'h0,         32'hBEEF_BEEF, 0));
    tbl.push_back(mk(0, SZ_WORD, 0, 32'h1001_0002, 32'h0,         32'h0000_0000, 1));
    tbl.push_back(mk(0, SZ_HALF, 1, 32'h1001_0001, 32'h0,         32'h0000_0000, 1));
    tbl.push_back(mk(1, SZ_WORD, 0, 32'h1001_0FFC, 32'h1234_5678, 32'h0000_0000, 0));
    tbl.push_back(mk(1, SZ_WORD, 0, 32'h1000_FFFC, 32'h5555_5555, 32'h0000_0000, 1));
    tbl.push_back(mk(0, SZ_WORD, 0, 32'h1001_0FFC, 32'h0,         32'h1234_5678, 0));
    tbl.push_back(mk(1, SZ_WORD, 0, 32'h1001_1000, 32'h7777_7777, 32'h0000_0000, 1));
    tbl.push_back(mk(0, SZ_RSVD, 0, 32'h1001_0000, 32'h0,         32'h0000_0000, 1));
    tbl.push_back(mk(1, SZ_RSVD, 0, 32'h1001_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1));
    tbl.push_back(mk(0, SZ_WORD, 0, 32'h1001_0000, 32'h0,         32'h8001_F07F, 0));

    // Back-to-back table on the LATENCY=0 instance.
    b2b.push_back(mk(1, SZ_WORD, 0, 32'h1001_0004, 32'hCAFE_F00D, 32'h0000_0000, 0));
    b2b.push_back(mk(0, SZ_WORD, 0, 32'h1001_0004, 32'h0,         32'hCAFE_F00D, 0));
    b2b.push_back(mk(1, SZ_BYTE, 0, 32'h1001_0005, 32'h0000_0011, 32'h0000_0000, 0));
    b2b.push_back(mk(0, SZ_WORD, 0, 32'h1001_0004, 32'h0,         32'hCAFE_110D, 0));
    b2b.push_back(mk(0, SZ_BYTE, 0, 32'h1001_0007, 32'h0,         32'h0000_00CA, 0));

    repeat (3) @(negedge clk);
    for (int s = 0; s < NI; s++) check_reset_outputs(s, $sformatf("por%0d", s));
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(0, tbl[i], $sformatf("t%0d", i));

    // Reset during WAIT on a store (LATENCY=3): dropped, target word unchanged.
    run_vec(1, mk(1, SZ_WORD, 0, 32'h1001_0010, 32'hA5A5_A5A5, 32'h0, 0), "rst_pre_st");
    run_vec(1, mk(0, SZ_WORD, 0, 32'h1001_0010, 32'h0, 32'hA5A5_A5A5, 0), "rst_pre_ld");
    @(negedge clk);
    drive(1, mk(1, SZ_WORD, 0, 32'h1001_0010, 32'h0BAD_F00D, 32'h0, 0));
    req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("rst_wait stall", 32'(stall[1]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(1, "rst_mid");
    // A load held through reset must be taken on the first edge after release.
    drive(1, mk(0, SZ_WORD, 0, 32'h1001_0010, 32'h0, 32'h0, 0));
    req_valid[1] = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n += int'(rsp_valid[1]);
    end
    check("rst_hold no_rsp", 32'(n), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_release accept", 32'(stall[1]), 32'd1);
    req_valid[1] = 1'b0;
    n = 0;
    while (!rsp_valid[1] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_release rsp", 32'(rsp_valid[1]), 32'd1);
    check("rst_keep rdata", rsp_rdata[1], 32'hA5A5_A5A5);
    check("rst_keep err", 32'(rsp_err[1]), 32'd0);

    // Zero wait states with req_valid held high: accept every 2 cycles.
    prev = 0;
    @(negedge clk);
    req_valid[2] = 1'b1;
    for (int i = 0; i < b2b.size(); i++) begin
      drive(2, b2b[i]);
      sbq.push_back('{rdata: b2b[i].er, err: b2b[i].ee});
      n = 0;
      while (!req_ready[2] && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("b2b%0d ready", i), 32'(req_ready[2]), 32'd1);
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      if (i > 0) check($sformatf("b2b%0d spacing", i), 32'(acc - prev), 32'd2);
      prev = acc;
      e = sbq.pop_front();
      check($sformatf("b2b%0d rsp_valid", i), 32'(rsp_valid[2]), 32'd1);
      check($sformatf("b2b%0d rdata", i), rsp_rdata[2], e.rdata);
      check($sformatf("b2b%0d err", i), 32'(rsp_err[2]), 32'(e.err));
`ifdef DMEM_DEBUG_PORT_EN
      if (i == 0) check("b2b dbg_data", dbg_data[2], 32'hCAFE_F00D);
`endif
    end
    req_valid[2] = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
